axi4_slave_mem_ctrl: RTL
========================

// Module: axi4_slave_mem_ctrl
// PURPOSE
//  Parametrised AXI4 slave with an integrated single-port word memory. Supports FIXED/INCR/WRAP bursts and narrow AxSIZE.
//  Full-width WSTRB byte enables; SLVERR/DECERR error responses; fair read/write arbitration.
//  Back-pressure-safe read pipeline. Top-level memory endpoint of the AXI4 slave subsystem.
// PARAMETERS
//  ADDR_WIDTH     32  byte address width
//  DATA_WIDTH     32  data bus width; 32, 64 or 128
//  ID_WIDTH       4   AxID/xID width
//  LEN_WIDTH      8   AxLEN width (beats = AxLEN+1, max 256)
//  MEM_ADDR_BITS  12  log2(memory depth in DATA_WIDTH words); must be <= ADDR_WIDTH-log2(DATA_WIDTH/8)
//  WRITE_FIRST    1   arbiter priority after reset (1 = write wins first tie)
// PORTS
//  CLK      in   1                    clock, all logic on rising edge
//  RST      in   1                    asynchronous, active-low reset
//  AW: AWVALID in 1; AWREADY out 1; AWID in ID_WIDTH; AWADDR in ADDR_WIDTH; AWLEN in LEN_WIDTH; AWSIZE in 3; AWBURST in 2
//  W:  WVALID in 1; WREADY out 1; WDATA in DATA_WIDTH; WSTRB in DATA_WIDTH/8; WLAST in 1
//  B:  BVALID out 1; BREADY in 1; BID out ID_WIDTH; BRESP out 2
//  AR: ARVALID in 1; ARREADY out 1; ARID in ID_WIDTH; ARADDR in ADDR_WIDTH; ARLEN in LEN_WIDTH; ARSIZE in 3; ARBURST in 2
//  R:  RVALID out 1; RREADY in 1; RID out ID_WIDTH; RDATA out DATA_WIDTH; RRESP out 2; RLAST out 1
// BEHAVIOUR
//  Reset (RST=0, async): all outputs 0; FSM=IDLE; beat counters 0; arbiter per WRITE_FIRST; memory contents NOT reset.
//  Reset mid-burst aborts the burst. Beats already written stay committed; no B/R response is issued afterwards.
//  FSM: IDLE -> WR_DATA -> WR_RESP -> IDLE ; IDLE -> RD_DATA -> IDLE. One burst in flight; no read/write overlap.
//  IDLE: AWREADY/ARREADY are combinational grant decodes; only one is high per cycle.
//   Only AWVALID -> grant W. Only ARVALID -> grant R. Both -> priority side wins, then priority toggles.
//   The handshake latches ID, ADDR, LEN, SIZE and BURST; the FSM leaves IDLE the next cycle.
//  Address gen: OFF=log2(DATA_WIDTH/8); word index = addr[MEM_ADDR_BITS+OFF-1:OFF].
//   FIXED: addr constant. INCR: addr += 1<<SIZE (aligned down after beat 0).
//   WRAP: wrap boundary = (LEN+1)<<SIZE; addr = start aligned to boundary, bits below boundary incremented modulo it.
//  Burst errors, flagged at AW/AR accept:
//   SLVERR if BURST=2'b11, or WRAP with LEN not in {1,3,7,15}, or (1<<SIZE) > DATA_WIDTH/8.
//   A SLVERR burst runs as INCR with all memory writes suppressed.
//  Per-beat DECERR if addr[ADDR_WIDTH-1:MEM_ADDR_BITS+OFF] != 0: write suppressed, or RDATA=0.
//  WR_DATA: WREADY=1; each W handshake writes only lanes with WSTRB[i]=1 at the current beat address.
//   Burst ends on beat count==AWLEN; WLAST is not used to end the burst.
//   If WLAST on any beat disagrees with (count==AWLEN), the burst is flagged SLVERR.
//  WR_RESP: BVALID=1 the cycle after the last W beat. BID=latched AWID.
//   BRESP = worst seen over the burst, DECERR > SLVERR > OKAY.
//   BVALID, BID and BRESP are held until BREADY, then IDLE.
//  RD_DATA: synchronous memory read, 1-cycle latency, feeding a 2-entry output skid buffer.
//   A read is issued only if the buffer will have space. First RVALID is 2 cycles after the AR handshake.
//   With RREADY held at 1, RD_DATA sustains 1 beat/cycle.
//   RID = latched ARID. RRESP per beat: DECERR > SLVERR > OKAY. RLAST=1 on beat ARLEN only.
//   RVALID and its payload are held stable while RREADY=0. After the RLAST handshake -> IDLE.
//  A reported SLVERR/DECERR never alters memory contents.
//  No EXOKAY: exclusive access is not supported.
//  Counters are LEN_WIDTH wide; LEN=255 gives 256 beats with no overflow.
// STRUCTURE
//  axi4_slave_pkg: resp_e (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3); burst_e (FIXED=0, INCR=1, WRAP=2, RSVD=3).
//  axi4_slave_pkg also holds state_e {IDLE, WR_DATA, WR_RESP, RD_DATA} and function resp_max().
//  Sub-module axi4_burst_addr_gen: load/step inputs, next beat address, burst_err output.
//   One instance, shared by read and write because the memory port is single.
//  Memory array, arbiter, FSM and R skid buffer live in this module.
// TESTING
//  1. INCR write: AW ID=3 ADDR=0x100 LEN=3 SIZE=2, 4 beats 0xA0..A3, WSTRB=0xF.
//     -> BID=3 BRESP=OKAY; INCR read of the same burst returns 0xA0..A3, RLAST on 4th beat.
//  2. WRAP read: ARADDR=0x108 LEN=3 SIZE=2 -> beat addrs 0x108, 0x10C, 0x100, 0x104.
//     -> RDATA 0xA2, 0xA3, 0xA0, 0xA1.
//  3. Byte strobe: write 0xFFFFFFFF to 0x200, then write 0x12345678 with WSTRB=0x5.
//     -> readback 0xFF34FF78.
//  4. Errors: AWBURST=2'b11 -> BRESP=SLVERR and memory unchanged.
//     ARADDR=0x4000 (MEM_ADDR_BITS=12, 32-bit) -> RRESP=DECERR, RDATA=0.
//     Wrong WLAST on beat 1 of LEN=3 -> SLVERR.
//  5. Tie + backpressure: AWVALID=ARVALID=1 same cycle -> write granted first, read next.
//     Random RREADY gaps on LEN=15 -> 16 beats, in order, no loss or duplication.
//  6. Reset mid-read (beat 5 of LEN=7) -> all outputs 0 immediately; a new burst afterwards completes normally.

Source files
------------

// File: rtl/axi4_slave_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axi4_slave_pkg
// Brief    : Shared response/burst/state encodings for the AXI4 memory slave.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_slave_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD_DATA = 2'd3
  } state_e;

  // Encoding order already ranks severity: DECERR > SLVERR > OKAY.
  function automatic resp_e resp_max(input resp_e a, input resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi4_burst_addr_gen
// Brief    : Beat address sequencer for FIXED/INCR/WRAP bursts with error flag.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_burst_addr_gen
  import axi4_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int OFF        = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [LEN_WIDTH-1:0]  i_load_len,
  input  logic [2:0]            i_load_size,
  input  logic [1:0]            i_load_burst,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_burst_err
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [2:0]            r_size;
  burst_e                r_burst;
  logic                  r_err;

  logic                  w_load_err;
  logic                  w_wrap_len_ok;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [ADDR_WIDTH-1:0] w_next;

  always_comb begin
    w_wrap_len_ok = (i_load_len == LEN_WIDTH'(1)) || (i_load_len == LEN_WIDTH'(3)) ||
                    (i_load_len == LEN_WIDTH'(7)) || (i_load_len == LEN_WIDTH'(15));
    w_load_err    = (i_load_burst == RSVD) ||
                    ((i_load_burst == WRAP) && !w_wrap_len_ok) ||
                    (i_load_size > 3'(OFF));
  end

  // Later beats step from the size-aligned address; WRAP keeps the bits above the window.
  always_comb begin
    w_incr      = ADDR_WIDTH'(1) << r_size;
    w_aligned   = r_addr & ~(w_incr - ADDR_WIDTH'(1));
    w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
    case (r_burst)
      FIXED:   w_next = r_addr;
      WRAP:    w_next = (r_addr & ~w_wrap_mask) | ((w_aligned + w_incr) & w_wrap_mask);
      default: w_next = w_aligned + w_incr;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= FIXED;
      r_err   <= 1'b0;
    end else if (i_load) begin
      r_addr  <= i_load_addr;
      r_len   <= i_load_len;
      r_size  <= i_load_size;
      r_burst <= w_load_err ? INCR : burst_e'(i_load_burst);
      r_err   <= w_load_err;
    end else if (i_step) begin
      r_addr  <= w_next;
    end
  end

  assign o_addr      = r_addr;
  assign o_burst_err = r_err;

endmodule
`default_nettype wire

// File: rtl/axi4_slave_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi4_slave_mem_ctrl
// Brief    : AXI4 slave endpoint with single-port word memory and R skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_slave_mem_ctrl
  import axi4_slave_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int LEN_WIDTH     = 8,
  parameter int MEM_ADDR_BITS = 12,
  parameter bit WRITE_FIRST   = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [LEN_WIDTH-1:0]    AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [LEN_WIDTH-1:0]    ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST
);

  localparam int c_nbytes = DATA_WIDTH / 8;
  localparam int c_off    = $clog2(c_nbytes);
  localparam int c_depth  = 1 << MEM_ADDR_BITS;

  state_e                  r_state;
  logic                    r_wr_prio;
  logic [ID_WIDTH-1:0]     r_id;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH-1:0]    r_cnt;
  logic                    r_wready;
  logic                    r_wlast_err;
  logic                    r_bvalid;
  resp_e                   r_bresp_acc;
  resp_e                   r_bresp;
  logic                    r_issue_done;
  logic                    r_pipe_vld;
  logic                    r_pipe_last;
  resp_e                   r_pipe_resp;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic [DATA_WIDTH-1:0]   r_fifo_data [2];
  resp_e                   r_fifo_resp [2];
  logic                    r_fifo_last [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_fifo_cnt;
  logic [DATA_WIDTH-1:0]   r_mem [c_depth];

  logic                     w_grant_w;
  logic                     w_grant_r;
  logic                     w_w_hs;
  logic                     w_pop;
  logic                     w_rd_issue;
  logic                     w_last_beat;
  logic                     w_wlast_err;
  logic                     w_decerr;
  logic                     w_burst_err;
  logic                     w_wr_block;
  logic [2:0]               w_occ;
  logic [ADDR_WIDTH-1:0]    w_beat_addr;
  logic [MEM_ADDR_BITS-1:0] w_idx;
  resp_e                    w_wr_resp;
  resp_e                    w_rd_resp;

  // Grants are gated by reset so every output is low while RST is asserted.
  always_comb begin
    w_grant_w = 1'b0;
    w_grant_r = 1'b0;
    if (RST && (r_state == IDLE)) begin
      if (AWVALID && ARVALID) begin
        w_grant_w = r_wr_prio;
        w_grant_r = !r_wr_prio;
      end else begin
        w_grant_w = AWVALID;
        w_grant_r = ARVALID;
      end
    end
  end

  axi4_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .OFF        (c_off)
  ) u_addr_gen (
    .CLK          (CLK),
    .RST          (RST),
    .i_load       (w_grant_w || w_grant_r),
    .i_step       (w_w_hs || w_rd_issue),
    .i_load_addr  (w_grant_w ? AWADDR  : ARADDR),
    .i_load_len   (w_grant_w ? AWLEN   : ARLEN),
    .i_load_size  (w_grant_w ? AWSIZE  : ARSIZE),
    .i_load_burst (w_grant_w ? AWBURST : ARBURST),
    .o_addr       (w_beat_addr),
    .o_burst_err  (w_burst_err)
  );

  always_comb begin
    w_idx       = w_beat_addr[MEM_ADDR_BITS+c_off-1:c_off];
    w_decerr    = (w_beat_addr >> (MEM_ADDR_BITS + c_off)) != '0;
    w_last_beat = (r_cnt == r_len);
    w_w_hs      = WVALID && r_wready;
    w_wlast_err = (WLAST != w_last_beat);
    w_wr_block  = w_burst_err || r_wlast_err || w_wlast_err || w_decerr;
    w_wr_resp   = w_decerr ? DECERR : ((w_burst_err || w_wlast_err) ? SLVERR : OKAY);
    w_rd_resp   = w_decerr ? DECERR : (w_burst_err ? SLVERR : OKAY);
    w_pop       = (r_fifo_cnt != 2'd0) && RREADY;
    // Projected occupancy once the in-flight memory word lands; must leave a free slot.
    w_occ       = 3'(r_fifo_cnt) + 3'(r_pipe_vld) - 3'(w_pop);
    w_rd_issue  = (r_state == RD_DATA) && !r_issue_done && (w_occ <= 3'd1);
  end

  always_ff @(posedge CLK) begin
    if (w_w_hs && !w_wr_block) begin
      for (int i = 0; i < c_nbytes; i++) begin
        if (WSTRB[i]) r_mem[w_idx][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
    if (w_rd_issue) r_rd_data <= r_mem[w_idx];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_wr_prio    <= WRITE_FIRST;
      r_id         <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_wready     <= 1'b0;
      r_wlast_err  <= 1'b0;
      r_bvalid     <= 1'b0;
      r_bresp_acc  <= OKAY;
      r_bresp      <= OKAY;
      r_issue_done <= 1'b0;
      r_pipe_vld   <= 1'b0;
      r_pipe_last  <= 1'b0;
      r_pipe_resp  <= OKAY;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_fifo_cnt   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_resp[i] <= OKAY;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (AWVALID && ARVALID) r_wr_prio <= !r_wr_prio;
          if (w_grant_w) begin
            r_state     <= WR_DATA;
            r_id        <= AWID;
            r_len       <= AWLEN;
            r_wready    <= 1'b1;
            r_wlast_err <= 1'b0;
            r_bresp_acc <= OKAY;
          end else if (w_grant_r) begin
            r_state      <= RD_DATA;
            r_id         <= ARID;
            r_len        <= ARLEN;
            r_issue_done <= 1'b0;
          end
        end
        WR_DATA: begin
          if (w_w_hs) begin
            r_bresp_acc <= resp_max(r_bresp_acc, w_wr_resp);
            if (w_wlast_err) r_wlast_err <= 1'b1;
            if (w_last_beat) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= resp_max(r_bresp_acc, w_wr_resp);
              r_state  <= WR_RESP;
            end else begin
              r_cnt <= r_cnt + LEN_WIDTH'(1);
            end
          end
        end
        WR_RESP: begin
          if (BREADY) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RD_DATA: begin
          if (w_rd_issue) begin
            if (w_last_beat) r_issue_done <= 1'b1;
            else             r_cnt        <= r_cnt + LEN_WIDTH'(1);
          end
          if (w_pop && r_fifo_last[r_rd_ptr]) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      r_pipe_vld <= w_rd_issue;
      if (w_rd_issue) begin
        r_pipe_resp <= w_rd_resp;
        r_pipe_last <= w_last_beat;
      end
      if (r_pipe_vld) begin
        r_fifo_data[r_wr_ptr] <= (r_pipe_resp == DECERR) ? '0 : r_rd_data;
        r_fifo_resp[r_wr_ptr] <= r_pipe_resp;
        r_fifo_last[r_wr_ptr] <= r_pipe_last;
        r_wr_ptr              <= !r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= !r_rd_ptr;
      r_fifo_cnt <= r_fifo_cnt + 2'(r_pipe_vld) - 2'(w_pop);
    end
  end

  assign AWREADY = w_grant_w;
  assign ARREADY = w_grant_r;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BID     = r_id;
  assign BRESP   = r_bresp;
  assign RVALID  = (r_fifo_cnt != 2'd0);
  assign RID     = r_id;
  assign RDATA   = r_fifo_data[r_rd_ptr];
  assign RRESP   = r_fifo_resp[r_rd_ptr];
  assign RLAST   = r_fifo_last[r_rd_ptr];

endmodule
`default_nettype wire
